// File: rtl/gpmc_mailbox.sv
// Register/FIFO mailbox behind the GPMC synchronizer: level host strobes become
// single commit events, host writes feed a TX FIFO, and host reads drain an RX FIFO.
module gpmc_mailbox #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FIFO_AW    = 4,
    parameter logic [ADDR_WIDTH-1:0] REG_BASE   = '0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'hB1E0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_cs,
    input  logic                  host_we,
    input  logic                  host_oe,
    input  logic [ADDR_WIDTH-1:0] host_address,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  irq
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [ADDR_WIDTH-1:0] OFF_ID  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OFF_ST  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] OFF_CTL = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] OFF_TX  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] OFF_RX  = ADDR_WIDTH'(4);
    localparam logic [FIFO_AW:0]      FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    logic                  wr_act, wr_q, wr_commit;
    logic                  rd_act, rd_q, rd_commit;
    logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ADDR_WIDTH-1:0] wr_off, rd_off, cur_off;

    logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
    logic [FIFO_AW:0]      tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [FIFO_AW:0]      tx_count, rx_count;
    logic                  tx_full, tx_empty, rx_full, rx_empty;

    logic                  ctl_wr, tx_flush, rx_flush, clr_sticky;
    logic                  tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
    logic                  irq_en, tx_ovf, rx_ovf;
    logic [15:0]           status;
    logic [DATA_WIDTH-1:0] rx_head, rd_mux;

    assign wr_act    = ~host_cs & ~host_we;
    assign rd_act    = ~host_cs & ~host_oe;
    assign wr_commit = wr_q & ~wr_act;
    assign rd_commit = rd_q & ~rd_act;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            wr_q <= wr_act;
            rd_q <= rd_act;
            if (wr_act) begin
                wr_addr_q <= host_address;
                wr_data_q <= host_wdata;
            end
            if (rd_act) begin
                rd_addr_q <= host_address;
            end
        end
    end

    assign wr_off  = wr_addr_q - REG_BASE;
    assign rd_off  = rd_addr_q - REG_BASE;
    assign cur_off = host_address - REG_BASE;

    assign tx_count = tx_wptr - tx_rptr;
    assign rx_count = rx_wptr - rx_rptr;
    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);

    assign ctl_wr      = wr_commit & (wr_off == OFF_CTL);
    assign tx_flush    = ctl_wr & wr_data_q[1];
    assign rx_flush    = ctl_wr & wr_data_q[2];
    assign clr_sticky  = ctl_wr & wr_data_q[3];
    assign tx_push_req = wr_commit & (wr_off == OFF_TX);
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_pop      = ~tx_empty & tx_ready;
    assign rx_push     = rx_valid & ~rx_full;
    assign rx_pop      = rd_commit & (rd_off == OFF_RX) & ~rx_empty;

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rptr[FIFO_AW-1:0]];
    assign rx_ready = ~rx_full;

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[FIFO_AW-1:0]] <= wr_data_q;
        if (rx_push) rx_mem[rx_wptr[FIFO_AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_flush) begin
                tx_wptr <= '0;
                tx_rptr <= '0;
            end else begin
                if (tx_push) tx_wptr <= tx_wptr + 1'b1;
                if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            end
            if (rx_flush) begin
                rx_wptr <= '0;
                rx_rptr <= '0;
            end else begin
                if (rx_push) rx_wptr <= rx_wptr + 1'b1;
                if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            end
        end
    end

    // A new overflow in the same clk as clr_sticky keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctl_wr) irq_en <= wr_data_q[0];
            if (tx_push_req & tx_full) tx_ovf <= 1'b1;
            else if (clr_sticky)       tx_ovf <= 1'b0;
            if (rx_valid & rx_full)    rx_ovf <= 1'b1;
            else if (clr_sticky)       rx_ovf <= 1'b0;
            irq <= irq_en & ~rx_empty;
        end
    end

    assign status  = {8'(rx_count), 2'b00, rx_ovf, tx_ovf, rx_full, rx_empty, tx_empty, tx_full};
    assign rx_head = rx_empty ? '0 : rx_mem[rx_rptr[FIFO_AW-1:0]];

    always_comb begin
        rd_mux = '0;
        case (cur_off)
            OFF_ID:  rd_mux = ID_VALUE;
            OFF_ST:  rd_mux = DATA_WIDTH'(status);
            OFF_CTL: rd_mux = DATA_WIDTH'(irq_en);
            OFF_RX:  rd_mux = rx_head;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rdata <= '0;
        end else begin
            host_rdata <= host_cs ? '0 : rd_mux;
        end
    end

endmodule

// File: tb/tb_gpmc_mailbox.sv
// Directed self-checking bench for gpmc_mailbox: register reads, TX/RX FIFO
// streaming, overflow/flush/sticky behaviour, irq timing and mid-write reset.
module tb_gpmc_mailbox;

    localparam logic [15:0] A_ID  = 16'd0;
    localparam logic [15:0] A_ST  = 16'd1;
    localparam logic [15:0] A_CTL = 16'd2;
    localparam logic [15:0] A_TX  = 16'd3;
    localparam logic [15:0] A_RX  = 16'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_cs, host_we, host_oe;
    logic [15:0] host_address, host_wdata, host_rdata;
    logic [15:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

    int total = 0;
    int bad   = 0;

    gpmc_mailbox dut (
        .clk          (clk),
        .reset        (reset),
        .host_cs      (host_cs),
        .host_we      (host_we),
        .host_oe      (host_oe),
        .host_address (host_address),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [15:0] a, input logic [15:0] d, input int hold);
        @(negedge clk);
        host_cs = 1'b0; host_we = 1'b0; host_address = a; host_wdata = d;
        repeat (hold) @(negedge clk);
        host_we = 1'b1; host_cs = 1'b1;
        @(negedge clk);
    endtask

    task automatic host_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        host_cs = 1'b0; host_oe = 1'b0; host_address = a;
        @(negedge clk);
        d = host_rdata;
        host_oe = 1'b1; host_cs = 1'b1;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        host_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic rx_feed(input logic [15:0] d);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1;
        host_cs = 1'b1; host_we = 1'b1; host_oe = 1'b1;
        host_address = '0; host_wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata", host_rdata, 16'h0000);
        check("rst_irq", irq, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        reset = 1'b0;

        read_check("id", A_ID, 16'hB1E0);
        read_check("status_idle", A_ST, 16'h0006);

        // TX stream basics
        host_write(A_TX, 16'h1234, 2);
        host_write(A_TX, 16'h5678, 2);
        check("tx_valid_2", tx_valid, 1'b1);
        check("tx_head_2", tx_data, 16'h1234);
        read_check("status_tx2", A_ST, 16'h0004);
        tx_ready = 1'b1;
        check("tx_word0", tx_data, 16'h1234);
        @(negedge clk);
        check("tx_word1", tx_data, 16'h5678);
        check("tx_valid_1", tx_valid, 1'b1);
        @(negedge clk);
        check("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // TX overflow and sticky clear
        for (int i = 0; i < 17; i++) host_write(A_TX, 16'h0100 + 16'(i), 2);
        read_check("status_tx_full_ovf", A_ST, 16'h0015);
        host_write(A_CTL, 16'h0008, 2);
        read_check("status_tx_ovf_clr", A_ST, 16'h0005);
        tx_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40 && tx_valid; k++) begin
            check("tx_fill_word", tx_data, 32'h0100 + 32'(cnt));
            cnt++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("tx_fill_count", cnt, 16);

        // RX stream and irq
        rx_feed(16'hA1A1);
        rx_feed(16'hB2B2);
        rx_feed(16'hC3C3);
        host_write(A_CTL, 16'h0001, 2);
        check("irq_lag", irq, 1'b0);
        @(negedge clk);
        check("irq_set", irq, 1'b1);
        read_check("status_rx3", A_ST, 16'h0302);
        read_check("rx_word0", A_RX, 16'hA1A1);
        read_check("rx_word1", A_RX, 16'hB2B2);
        read_check("rx_word2", A_RX, 16'hC3C3);
        check("irq_hold_after_pop", irq, 1'b1);
        @(negedge clk);
        check("irq_clear", irq, 1'b0);
        read_check("rx_empty_read", A_RX, 16'h0000);
        read_check("status_rx_empty", A_ST, 16'h0006);
        read_check("ctl_readback", A_CTL, 16'h0001);

        // RX full, backpressure, overflow, flush
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1; rx_data = 16'h2000 + 16'(i);
            @(negedge clk);
        end
        check("rx_ready_full", rx_ready, 1'b0);
        rx_data = 16'hDEAD;
        @(negedge clk);
        rx_valid = 1'b0;
        check("irq_rx_full", irq, 1'b1);
        read_check("status_rx_full_ovf", A_ST, 16'h102A);
        read_check("rx_full_head", A_RX, 16'h2000);
        read_check("status_rx15", A_ST, 16'h0F22);
        host_write(A_CTL, 16'h0005, 2);
        read_check("status_rx_flush", A_ST, 16'h0026);
        host_write(A_CTL, 16'h0008, 2);
        read_check("status_rx_ovf_clr", A_ST, 16'h0006);
        read_check("ctl_cleared", A_CTL, 16'h0000);

        // Long write strobe yields one push
        host_write(A_TX, 16'hBEEF, 20);
        check("long_wr_valid", tx_valid, 1'b1);
        check("long_wr_data", tx_data, 16'hBEEF);
        tx_ready = 1'b1;
        @(negedge clk);
        check("long_wr_single", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // tx_flush collides with a pending pop
        for (int i = 0; i < 5; i++) host_write(A_TX, 16'h0300 + 16'(i), 2);
        @(negedge clk);
        host_cs = 1'b0; host_we = 1'b0; host_address = A_CTL; host_wdata = 16'h0002;
        repeat (2) @(negedge clk);
        host_we = 1'b1; host_cs = 1'b1; tx_ready = 1'b1;
        check("flush_pop_pending", tx_valid, 1'b1);
        @(negedge clk);
        check("flush_wins", tx_valid, 1'b0);
        tx_ready = 1'b0;
        read_check("status_tx_flush", A_ST, 16'h0006);

        // Reset in the middle of a TX_DATA write
        rx_feed(16'h4444);
        host_write(A_CTL, 16'h0001, 2);
        @(negedge clk);
        check("irq_before_reset", irq, 1'b1);
        @(negedge clk);
        host_cs = 1'b0; host_we = 1'b0; host_address = A_TX; host_wdata = 16'h5555;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        host_cs = 1'b1; host_we = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_rx_ready", rx_ready, 1'b1);
        check("mid_rst_irq", irq, 1'b0);
        check("mid_rst_rdata", host_rdata, 16'h0000);
        read_check("mid_rst_status", A_ST, 16'h0006);
        read_check("mid_rst_ctl", A_CTL, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
